// File: rtl/cla32_stream_accum.sv
// Streaming packet accumulator built around a combinational 32-bit carry-lookahead adder.
// Optional feature: define CLA_SAT_EN to saturate the packet sum on the first carry-out.
module cla32_stream_accum #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic [CNT_W-1:0] out_carries,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t           state;
  logic [31:0]      acc;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] carries;
`ifdef CLA_SAT_EN
  logic             sat;
  logic             sat_n;
`endif

  logic [31:0]      op_a;
  logic [31:0]      gen;
  logic [31:0]      prop;
  logic [31:0]      gp;
  logic [31:0]      pp;
  logic [31:0]      sum;
  logic             cout;
  logic [4:0]       hi;
  logic [4:0]       lo;

  logic             accept;
  logic             first;
  logic [31:0]      acc_n;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] car_base;
  logic [CNT_W-1:0] car_n;

  // Kogge-Stone prefix tree: gp[i] ends up as the carry out of bit i (carry-in is 0).
  always_comb begin
    op_a = (state == IDLE) ? '0 : acc;
    gen  = op_a & in_data;
    prop = op_a ^ in_data;
    gp   = gen;
    pp   = prop;
    hi   = '0;
    lo   = '0;
    for (int unsigned lvl = 0; lvl < 5; lvl++) begin
      for (int unsigned i = 31; i >= (32'd1 << lvl); i--) begin
        hi     = 5'(i);
        lo     = 5'(i - (32'd1 << lvl));
        gp[hi] = gp[hi] | (pp[hi] & gp[lo]);
        pp[hi] = pp[hi] & pp[lo];
      end
    end
    sum  = prop ^ {gp[30:0], 1'b0};
    cout = gp[31];
  end

  always_comb begin
    accept   = in_valid && in_ready;
    first    = (state == IDLE);
    cnt_n    = first ? CNT_W'(1) : ((&cnt) ? cnt : cnt + 1'b1);
    car_base = first ? '0 : carries;
    car_n    = (cout && !(&car_base)) ? car_base + 1'b1 : car_base;
`ifdef CLA_SAT_EN
    sat_n    = (!first && sat) || cout;
    acc_n    = sat_n ? '1 : sum;
`else
    acc_n    = sum;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      carries   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
`ifdef CLA_SAT_EN
      sat       <= 1'b0;
`endif
    end else if (clear) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      carries   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
`ifdef CLA_SAT_EN
      sat       <= 1'b0;
`endif
    end else if (accept) begin
      acc     <= acc_n;
      cnt     <= cnt_n;
      carries <= car_n;
`ifdef CLA_SAT_EN
      sat     <= sat_n;
`endif
      if (in_last) begin
        state     <= HOLD;
        in_ready  <= 1'b0;
        out_valid <= 1'b1;
      end else begin
        state <= ACCUM;
      end
    end else if (state == HOLD && out_ready) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end
  end

  assign out_sum     = acc;
  assign out_carries = carries;
  assign out_count   = cnt;

endmodule

// File: tb/tb_cla32_stream_accum.sv
// Self-checking bench for cla32_stream_accum: two instances (CNT_W=8 and CNT_W=2)
// share stimulus; expected values come from vector tables and an arithmetic packet model.
module tb_cla32_stream_accum;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_data = '0;

  logic        in_ready8, out_valid8, in_ready2, out_valid2;
  logic [31:0] sum8, sum2;
  logic [7:0]  car8, cnt8;
  logic [1:0]  car2, cnt2;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

`ifdef CLA_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [31:0] d [5];
    int unsigned len;
    logic [31:0] sum_wrap;
    logic [31:0] sum_sat;
    int unsigned car_wrap;
    int unsigned car_sat;
  } vec_t;

  vec_t        tv[$];
  logic [31:0] pkt[$];

  always #5 clk = ~clk;

  cla32_stream_accum #(.CNT_W(8)) u8 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready8),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid8), .out_ready(out_ready),
    .out_sum(sum8), .out_carries(car8), .out_count(cnt8)
  );

  cla32_stream_accum #(.CNT_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid2), .out_ready(out_ready),
    .out_sum(sum2), .out_carries(car2), .out_count(cnt2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned satn(input int unsigned x, input int unsigned mx);
    return (x > mx) ? mx : x;
  endfunction

  task automatic add_vec(input logic [31:0] d0, d1, d2, d3, d4, input int unsigned len,
                         input logic [31:0] sw, ss, input int unsigned cw, cs);
    vec_t v;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3; v.d[4] = d4;
    v.len = len; v.sum_wrap = sw; v.sum_sat = ss; v.car_wrap = cw; v.car_sat = cs;
    tv.push_back(v);
  endtask

  // Spec-level model: 33-bit add per beat, count carries, stick at all-ones once saturated.
  task automatic model(output logic [31:0] s, output int unsigned cnt, output int unsigned car);
    logic [32:0] t;
    logic [31:0] r;
    bit          sat;
    r = '0; sat = 1'b0; car = 0;
    foreach (pkt[i]) begin
      t = {1'b0, r} + {1'b0, pkt[i]};
      car += int'(t[32]);
      sat = sat | t[32];
      r = (SAT && sat) ? 32'hFFFF_FFFF : t[31:0];
    end
    s = r;
    cnt = pkt.size();
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_out_valid8"}, out_valid8, 0);
    chk({tag, "_out_valid2"}, out_valid2, 0);
    chk({tag, "_in_ready8"}, in_ready8, 1);
    chk({tag, "_sum8"}, sum8, 0);
    chk({tag, "_count8"}, cnt8, 0);
    chk({tag, "_carries8"}, car8, 0);
    chk({tag, "_count2"}, cnt2, 0);
  endtask

  task automatic send_pkt(input int unsigned gapmax);
    int unsigned g, w;
    for (int i = 0; i < pkt.size(); i++) begin
      g = (gapmax == 0) ? 0 : $urandom_range(gapmax, 0);
      in_valid = 1'b0;
      repeat (g) tick();
      in_valid = 1'b1;
      in_data  = pkt[i];
      in_last  = (i == pkt.size() - 1);
      w = 0;
      while (!in_ready8 && w < 20) begin
        tick();
        w++;
      end
      if (w == 20) chk("in_ready_wait", in_ready8, 1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [31:0] s,
                               input int unsigned cnt, input int unsigned car);
    chk({tag, "_out_valid8"}, out_valid8, 1);
    chk({tag, "_out_valid2"}, out_valid2, 1);
    chk({tag, "_in_ready8"}, in_ready8, 0);
    chk({tag, "_sum8"}, sum8, s);
    chk({tag, "_sum2"}, sum2, s);
    chk({tag, "_count8"}, cnt8, satn(cnt, 255));
    chk({tag, "_count2"}, cnt2, satn(cnt, 3));
    chk({tag, "_carries8"}, car8, satn(car, 255));
    chk({tag, "_carries2"}, car2, satn(car, 3));
  endtask

  task automatic finish_pkt(input string tag, input int unsigned stall, input logic [31:0] s,
                            input int unsigned cnt);
    out_ready = 1'b0;
    repeat (stall) begin
      tick();
      chk({tag, "_hold_valid"}, out_valid8, 1);
      chk({tag, "_hold_in_ready"}, in_ready8, 0);
      chk({tag, "_hold_sum"}, sum8, s);
      chk({tag, "_hold_count"}, cnt8, satn(cnt, 255));
    end
    out_ready = 1'b1;
    tick();
    chk({tag, "_done_valid"}, out_valid8, 0);
    chk({tag, "_done_in_ready"}, in_ready8, 1);
    chk({tag, "_done_in_ready2"}, in_ready2, 1);
  endtask

  initial begin
    logic [31:0] es;
    int unsigned ec, ea, len;

    add_vec(32'd1, 32'd2, 32'd3, 0, 0, 3, 32'd6, 32'd6, 0, 0);
    add_vec(32'hFFFF_FFFF, 32'd2, 0, 0, 0, 2, 32'd1, 32'hFFFF_FFFF, 1, 1);
    add_vec(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 5,
            32'h8000_0000, 32'hFFFF_FFFF, 2, 4);
    add_vec(32'h1234_5678, 0, 0, 0, 0, 1, 32'h1234_5678, 32'h1234_5678, 0, 0);
    add_vec(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 0, 0, 3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 2);
    add_vec(32'hAAAA_AAAA, 32'h5555_5555, 32'd1, 0, 0, 3, 32'd0, 32'hFFFF_FFFF, 1, 1);

    #12;
    check_idle_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_idle_zero("post_reset");

    // Table vectors, out_ready held high: result visible for exactly one cycle.
    out_ready = 1'b1;
    foreach (tv[k]) begin
      pkt.delete();
      for (int unsigned j = 0; j < tv[k].len; j++) pkt.push_back(tv[k].d[j]);
      send_pkt(0);
      expect_result($sformatf("vec%0d", k), SAT ? tv[k].sum_sat : tv[k].sum_wrap, tv[k].len,
                    SAT ? tv[k].car_sat : tv[k].car_wrap);
      tick();
      chk($sformatf("vec%0d_one_cycle_valid", k), out_valid8, 0);
      chk($sformatf("vec%0d_ready_back", k), in_ready8, 1);
    end

    // Output back-pressure for five cycles.
    pkt.delete();
    pkt.push_back(32'h1234_5678);
    out_ready = 1'b0;
    send_pkt(0);
    expect_result("stall", 32'h1234_5678, 1, 0);
    finish_pkt("stall", 5, 32'h1234_5678, 1);

    // Clear mid-packet drops it.
    in_valid = 1'b1; in_last = 1'b0; in_data = 32'd10; tick();
    in_data = 32'd20; tick();
    in_valid = 1'b0; clear = 1'b1; tick();
    clear = 1'b0;
    check_idle_zero("clear_mid");
    pkt.delete(); pkt.push_back(32'd5);
    send_pkt(0);
    expect_result("after_clear", 32'd5, 1, 0);
    finish_pkt("after_clear", 0, 32'd5, 1);

    // Clear coinciding with a last beat drops the beat.
    in_valid = 1'b1; in_last = 1'b1; in_data = 32'd99; clear = 1'b1; tick();
    in_valid = 1'b0; in_last = 1'b0; clear = 1'b0;
    check_idle_zero("clear_beat");

    // Clear while holding a result discards it without a handshake.
    pkt.delete(); pkt.push_back(32'd3);
    out_ready = 1'b0;
    send_pkt(0);
    expect_result("pre_clear_hold", 32'd3, 1, 0);
    clear = 1'b1; tick(); clear = 1'b0;
    check_idle_zero("clear_hold");

    // Asynchronous reset mid-packet.
    out_ready = 1'b1;
    in_valid = 1'b1; in_last = 1'b0; in_data = 32'd7; tick();
    in_data = 32'd8; tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_idle_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    pkt.delete(); pkt.push_back(32'd4);
    send_pkt(0);
    expect_result("after_reset", 32'd4, 1, 0);
    finish_pkt("after_reset", 0, 32'd4, 1);

    // Random packets with input gaps and output stalls.
    for (int n = 0; n < 40; n++) begin
      pkt.delete();
      len = (n == 39) ? 260 : $urandom_range(8, 1);
      for (int unsigned j = 0; j < len; j++)
        pkt.push_back($urandom_range(3, 0) == 0 ? ($urandom | 32'hC000_0000) :
                      ($urandom_range(1, 0) == 1 ? $urandom : $urandom_range(1000, 0)));
      model(es, ec, ea);
      out_ready = 1'b0;
      send_pkt((n == 39) ? 0 : 2);
      expect_result($sformatf("rand%0d", n), es, ec, ea);
      finish_pkt($sformatf("rand%0d", n), $urandom_range(2, 0), es, ec);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
